// File: rtl/and4_sweep_checker_pkg.sv
// and4_sweep_checker_pkg: shared state encoding and sweep constants
package and4_sweep_checker_pkg;
  localparam int NUM_VECS = 16;
  localparam int VEC_W = 4;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/and4_sweep_checker_hold_timer.sv
// hold_timer: counts 0..HOLD_CYCLES-1 while enabled, flags the last count and wraps
module hold_timer #(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [CNT_W-1:0] count;
  assign last = count == CNT_W'(HOLD_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= last ? '0 : count + 1'b1;
endmodule

// File: rtl/and4_sweep_checker.sv
// and4_sweep_checker: sweeps all 16 AND inputs, holds each, and scores the sampled output
module and4_sweep_checker
  import and4_sweep_checker_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       vec_a,
  output logic       vec_b,
  output logic       vec_c,
  output logic       vec_d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_err_vec
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  state_t state, state_nxt;
  logic [VEC_W-1:0] vec;
  logic arm, last, cmp, last_vec, miss;
  assign arm = start && state != S_RUN;
  assign cmp = state == S_RUN && last;
  assign last_vec = vec == VEC_W'(NUM_VECS - 1);
  assign miss = cmp && (dut_out != &vec);
  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (arm),
    .en   (state == S_RUN),
    .last (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  always_comb state_nxt = arm ? S_RUN : (cmp && last_vec) ? S_DONE : state;
  // Vector stops at 15 on the final compare so DONE shows the last vector driven.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec <= '0;
      err_count <= '0;
      first_err_vec <= '0;
    end else if (arm) begin
      vec <= '0;
      err_count <= '0;
      first_err_vec <= '0;
    end else if (cmp) begin
      if (!last_vec) vec <= vec + 1'b1;
      if (miss) err_count <= err_count + 5'd1;
      if (miss && err_count == '0) first_err_vec <= vec;
    end
  assign {vec_a, vec_b, vec_c, vec_d} = vec;
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  assign pass = done && err_count == '0;
endmodule

// File: tb/tb_and4_sweep_checker.sv
// tb_and4_sweep_checker: random and directed sweeps against a cycle-count model
module tb_and4_sweep_checker;
  logic clk = 0, rst_n = 0;
  logic st0 = 0, st1 = 0;
  logic [1:0] rnd = '0;
  int mode0 = 0, mode1 = 0;
  logic va0, vb0, vc0, vd0, busy0, done0, pass0;
  logic va1, vb1, vc1, vd1, busy1, done1, pass1;
  logic [4:0] err0, err1;
  logic [3:0] fev0, fev1;
  logic dout0, dout1;
  logic [15:0] act0, act1;
  int total = 0, bad = 0;
  int h[2] = '{10, 1};
  bit m_run[2], m_done[2];
  int m_cyc[2], m_err[2], m_first[2], m_vec[2];

  always #5 clk = ~clk;

  assign dout0 = mode0 == 0 ? (va0 & vb0 & vc0 & vd0) : mode0 == 1 ? 1'b0 : mode0 == 2 ? 1'b1 : rnd[0];
  assign dout1 = mode1 == 0 ? (va1 & vb1 & vc1 & vd1) : mode1 == 1 ? 1'b0 : mode1 == 2 ? 1'b1 : rnd[1];
  assign act0 = {va0, vb0, vc0, vd0, busy0, done0, pass0, err0, fev0};
  assign act1 = {va1, vb1, vc1, vd1, busy1, done1, pass1, err1, fev1};

  and4_sweep_checker #(.HOLD_CYCLES(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .dut_out(dout0),
    .vec_a(va0), .vec_b(vb0), .vec_c(vc0), .vec_d(vd0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_vec(fev0)
  );
  and4_sweep_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .dut_out(dout1),
    .vec_a(va1), .vec_b(vb1), .vec_c(vc1), .vec_d(vd1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_vec(fev1)
  );

  // Model: the sweep is a count of cycles since start; vector = cycles / hold.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_done[i] = 0; m_cyc[i] = 0; m_err[i] = 0; m_first[i] = 0; m_vec[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic s, d;
        int v;
        s = i == 0 ? st0 : st1;
        d = i == 0 ? dout0 : dout1;
        v = m_cyc[i] / h[i];
        if (!m_run[i] && s) begin
          m_run[i] = 1; m_done[i] = 0; m_cyc[i] = 0; m_err[i] = 0; m_first[i] = 0; m_vec[i] = 0;
        end else if (m_run[i]) begin
          if ((m_cyc[i] + 1) % h[i] == 0 && d != (v == 15)) begin
            if (m_err[i] == 0) m_first[i] = v;
            m_err[i]++;
          end
          m_cyc[i]++;
          if (m_cyc[i] == 16 * h[i]) begin
            m_run[i] = 0;
            m_done[i] = 1;
          end
          m_vec[i] = m_cyc[i] / h[i] > 15 ? 15 : m_cyc[i] / h[i];
        end
      end
    end
  end

  function automatic logic [15:0] exp_of(int i);
    return {4'(m_vec[i]), 1'(m_run[i]), 1'(m_done[i]), 1'(m_done[i] && m_err[i] == 0),
            5'(m_err[i]), 4'(m_first[i])};
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [15:0] a;
      a = i == 0 ? act0 : act1;
      total++;
      if (a !== exp_of(i)) begin
        bad++;
        $display("FAIL cycle dut%0d t=%0t got=%h want=%h", i, $time, a, exp_of(i));
      end
    end
  end

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  task automatic pulse0();
    st0 = 1;
    @(negedge clk);
    st0 = 0;
  endtask

  task automatic wait_vec0(input logic [3:0] v);
    int n = 0;
    while ({va0, vb0, vc0, vd0} != v && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wait_vec_timeout", n < 400, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_err", err0, 0);
    pulse0();
    repeat (159) @(negedge clk);
    chk("t1_done_early", done0, 0);
    @(negedge clk);
    chk("t1_done", done0, 1);
    chk("t1_pass", pass0, 1);
    chk("t1_err", err0, 0);
    chk("t1_first", fev0, 0);
    mode0 = 1;
    pulse0();
    repeat (160) @(negedge clk);
    chk("t2_err", err0, 1);
    chk("t2_first", fev0, 15);
    chk("t2_pass", pass0, 0);
    mode0 = 2;
    pulse0();
    repeat (160) @(negedge clk);
    chk("t3_err", err0, 15);
    chk("t3_first", fev0, 0);
    chk("t3_pass", pass0, 0);
    pulse0();
    wait_vec0(4'd7);
    chk("t4_err_pre", err0, 7);
    rst_n = 0;
    #1;
    chk("t4_busy", busy0, 0);
    chk("t4_vec", {va0, vb0, vc0, vd0}, 0);
    chk("t4_err", err0, 0);
    @(negedge clk);
    rst_n = 1;
    mode0 = 0;
    @(negedge clk);
    pulse0();
    repeat (160) @(negedge clk);
    chk("t4_pass", pass0, 1);
    mode0 = 2;
    pulse0();
    repeat (35) @(negedge clk);
    chk("t5_vec3", {va0, vb0, vc0, vd0}, 3);
    pulse0();
    repeat (123) @(negedge clk);
    chk("t5_done_early", done0, 0);
    @(negedge clk);
    chk("t5_done", done0, 1);
    chk("t5_err", err0, 15);
    mode0 = 0;
    pulse0();
    chk("t5_clr_err", err0, 0);
    chk("t5_clr_done", done0, 0);
    chk("t5_busy", busy0, 1);
    repeat (160) @(negedge clk);
    chk("t5_pass", pass0, 1);
    st1 = 1;
    @(negedge clk);
    st1 = 0;
    repeat (15) @(negedge clk);
    chk("t6_done_early", done1, 0);
    @(negedge clk);
    chk("t6_done", done1, 1);
    chk("t6_pass", pass1, 1);
    mode0 = 3;
    mode1 = 3;
    repeat (3000) begin
      @(negedge clk);
      rnd = 2'($urandom);
      st0 = $urandom_range(0, 39) == 0;
      st1 = $urandom_range(0, 7) == 0;
    end
    @(negedge clk);
    st0 = 0;
    st1 = 0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
